// File: rtl/eth_link_sequencer.sv
// eth_link_sequencer
// Bring-up and recovery controller for one 10GBASE-R lane. It steps the
// transceiver through full reset, QPLL lock, TX/RX reset completion and PHY
// block lock. Each stage has a timeout, and the number of retries is bounded.
// Once the link is up, it watches PHY status and recovers the RX datapath on
// link loss.
//
// Ports
//   clk, rst_n               free-running clock, async active-low reset
//   enable, pll_lock         both high to run; either low forces DISABLED
//   qpll_lock                transceiver QPLL0 lock
//   tx_reset_done            TX reset-done flag
//   rx_reset_done            RX reset-done flag
//   userclk_tx_active        TX user clock active flag
//   userclk_rx_active        RX user clock active flag
//   rx_block_lock            PHY block lock
//   rx_high_ber              PHY high-BER flag
//   clr_counters             single-cycle pulse, clears link_drops
//   gt_reset_all             full transceiver reset
//   rx_reset_datapath        RX datapath reset
//   link_up, fault           state flags
//   state                    current state encoding
//   retry_count              timeouts since the last successful link-up
//   link_drops               saturating count of PHY-loss exits from LINK_UP
//
// state      | meaning
// DISABLED   | held off; full reset asserted, retries cleared
// RESET_ALL  | full transceiver reset pulse
// WAIT_PLL   | waiting for QPLL lock
// WAIT_TX    | waiting for TX reset done and TX user clock
// WAIT_RX    | waiting for RX reset done and RX user clock
// WAIT_BLOCK | counting consecutive good PHY cycles
// LINK_UP    | link operational
// RX_RESET   | RX datapath reset pulse
// FAULT      | retries exhausted; only a disable exits this state
module eth_link_sequencer #(
  parameter int unsigned RESET_PULSE    = 16,
  parameter int unsigned RX_RESET_PULSE = 16,
  parameter int unsigned STAGE_TIMEOUT  = 1_000_000,
  parameter int unsigned LOCK_TIMEOUT   = 4_000_000,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned MAX_RETRIES    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pll_lock,
  input  logic        qpll_lock,
  input  logic        tx_reset_done,
  input  logic        rx_reset_done,
  input  logic        userclk_tx_active,
  input  logic        userclk_rx_active,
  input  logic        rx_block_lock,
  input  logic        rx_high_ber,
  input  logic        clr_counters,
  output logic        gt_reset_all,
  output logic        rx_reset_datapath,
  output logic        link_up,
  output logic        fault,
  output logic [3:0]  state,
  output logic [7:0]  retry_count,
  output logic [15:0] link_drops
);

  localparam logic [3:0] S_DISABLED   = 4'd0;
  localparam logic [3:0] S_RESET_ALL  = 4'd1;
  localparam logic [3:0] S_WAIT_PLL   = 4'd2;
  localparam logic [3:0] S_WAIT_TX    = 4'd3;
  localparam logic [3:0] S_WAIT_RX    = 4'd4;
  localparam logic [3:0] S_WAIT_BLOCK = 4'd5;
  localparam logic [3:0] S_LINK_UP    = 4'd6;
  localparam logic [3:0] S_RX_RESET   = 4'd7;
  localparam logic [3:0] S_FAULT      = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] stable_q, stable_d;
  logic [7:0]  retry_q, retry_d, retry_inc;
  logic [15:0] drops_q, drops_d;
  logic        gt_reset_q, rx_reset_q, link_up_q, fault_q;
  logic        go, good, stage_to, lock_to;
  logic        to_hit, drop_evt;
  logic [3:0]  to_target;

  assign go        = enable & pll_lock;
  assign good      = rx_block_lock & ~rx_high_ber;
  assign stage_to  = (timer_q == 32'(STAGE_TIMEOUT - 1));
  assign lock_to   = (timer_q == 32'(LOCK_TIMEOUT - 1));
  assign retry_inc = retry_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    stable_d  = '0;
    to_hit    = 1'b0;
    to_target = S_RESET_ALL;
    drop_evt  = 1'b0;
    case (state_q)
      S_DISABLED: begin
        retry_d = '0;
        state_d = S_RESET_ALL;
      end
      S_RESET_ALL: begin
        if (timer_q == 32'(RESET_PULSE - 1)) state_d = S_WAIT_PLL;
      end
      S_WAIT_PLL: begin
        if (qpll_lock) state_d = S_WAIT_TX;
        else           to_hit  = stage_to;
      end
      S_WAIT_TX: begin
        if (tx_reset_done && userclk_tx_active) state_d = S_WAIT_RX;
        else                                    to_hit  = stage_to;
      end
      S_WAIT_RX: begin
        if (rx_reset_done && userclk_rx_active) state_d = S_WAIT_BLOCK;
        else                                    to_hit  = stage_to;
      end
      S_WAIT_BLOCK: begin
        stable_d = good ? stable_q + 32'd1 : '0;
        if (good && (stable_q + 32'd1 == 32'(LOCK_STABLE))) begin
          state_d = S_LINK_UP;
          retry_d = '0;
        end else begin
          to_hit    = lock_to;
          to_target = S_RX_RESET;
        end
      end
      S_LINK_UP: begin
        // Losing the TX side needs a full reset; a PHY-only loss needs
        // just the RX datapath.
        if (!qpll_lock || !tx_reset_done) begin
          state_d = S_RESET_ALL;
        end else if (!good) begin
          state_d  = S_RX_RESET;
          drop_evt = 1'b1;
        end
      end
      S_RX_RESET: begin
        if (timer_q == 32'(RX_RESET_PULSE - 1)) state_d = S_WAIT_RX;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_DISABLED;
    endcase

    if (to_hit) begin
      retry_d = retry_inc;
      state_d = (retry_inc == 8'(MAX_RETRIES)) ? S_FAULT : to_target;
    end

    if (!go) begin
      state_d  = S_DISABLED;
      retry_d  = '0;
      stable_d = '0;
      drop_evt = 1'b0;
    end
  end

  assign timer_d = (state_d != state_q) ? '0 : timer_q + 32'd1;

  always_comb begin
    drops_d = drops_q;
    if (clr_counters)                        drops_d = '0;
    else if (drop_evt && drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DISABLED;
      timer_q    <= '0;
      stable_q   <= '0;
      retry_q    <= '0;
      drops_q    <= '0;
      gt_reset_q <= 1'b1;
      rx_reset_q <= 1'b0;
      link_up_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      stable_q   <= stable_d;
      retry_q    <= retry_d;
      drops_q    <= drops_d;
      // Outputs are decoded from the next state so they move with state_q.
      gt_reset_q <= (state_d == S_DISABLED) || (state_d == S_RESET_ALL) ||
                    (state_d == S_FAULT);
      rx_reset_q <= (state_d == S_RX_RESET);
      link_up_q  <= (state_d == S_LINK_UP);
      fault_q    <= (state_d == S_FAULT);
    end
  end

  assign state             = state_q;
  assign retry_count       = retry_q;
  assign link_drops        = drops_q;
  assign gt_reset_all      = gt_reset_q;
  assign rx_reset_datapath = rx_reset_q;
  assign link_up           = link_up_q;
  assign fault             = fault_q;

endmodule

// File: tb/tb_eth_link_sequencer.sv
// Testbench for eth_link_sequencer.
// Expected behaviour is a timeline of state durations. Each duration is
// computed from the pulse, timeout and stable-count parameters together
// with the sample at which the bench raises each status input.
module tb_eth_link_sequencer;

  localparam int RP  = 4;
  localparam int RRP = 3;
  localparam int ST  = 20;
  localparam int LT  = 50;
  localparam int LS  = 8;
  localparam int MR  = 3;

  localparam logic [3:0] S_DIS = 4'd0, S_RST = 4'd1, S_PLL = 4'd2, S_TX = 4'd3,
                         S_RX  = 4'd4, S_BLK = 4'd5, S_UP  = 4'd6, S_RXR = 4'd7,
                         S_FLT = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, pll_lock = 1'b0, qpll_lock = 1'b0;
  logic        tx_reset_done = 1'b0, rx_reset_done = 1'b0;
  logic        userclk_tx_active = 1'b0, userclk_rx_active = 1'b0;
  logic        rx_block_lock = 1'b0, rx_high_ber = 1'b0, clr_counters = 1'b0;
  logic        gt_reset_all, rx_reset_datapath, link_up, fault;
  logic [3:0]  state;
  logic [7:0]  retry_count;
  logic [15:0] link_drops;

  int errors = 0;
  int checks = 0;
  int m_retry = 0;
  int m_drops = 0;

  always #5 clk = ~clk;

  eth_link_sequencer #(
    .RESET_PULSE(RP), .RX_RESET_PULSE(RRP), .STAGE_TIMEOUT(ST),
    .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pll_lock(pll_lock),
    .qpll_lock(qpll_lock), .tx_reset_done(tx_reset_done),
    .rx_reset_done(rx_reset_done), .userclk_tx_active(userclk_tx_active),
    .userclk_rx_active(userclk_rx_active), .rx_block_lock(rx_block_lock),
    .rx_high_ber(rx_high_ber), .clr_counters(clr_counters),
    .gt_reset_all(gt_reset_all), .rx_reset_datapath(rx_reset_datapath),
    .link_up(link_up), .fault(fault), .state(state),
    .retry_count(retry_count), .link_drops(link_drops)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] s);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".gt_reset_all"}, 32'(gt_reset_all), 32'(s == S_DIS || s == S_RST || s == S_FLT));
    chk({tag, ".rx_reset_datapath"}, 32'(rx_reset_datapath), 32'(s == S_RXR));
    chk({tag, ".link_up"}, 32'(link_up), 32'(s == S_UP));
    chk({tag, ".fault"}, 32'(fault), 32'(s == S_FLT));
    chk({tag, ".retry_count"}, 32'(retry_count), m_retry);
    chk({tag, ".link_drops"}, 32'(link_drops), m_drops);
  endtask

  task automatic hold(input string tag, input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      check_state(tag, s);
      step();
    end
  endtask

  task automatic status_low();
    qpll_lock = 0; tx_reset_done = 0; userclk_tx_active = 0;
    rx_reset_done = 0; userclk_rx_active = 0; rx_block_lock = 0; rx_high_ber = 0;
  endtask

  // From the first RESET_ALL sample to the first WAIT_RX sample.
  // A status raised at sample k of a stage leaves that stage after k+1 samples.
  task automatic to_wait_rx(input string tag, input int kp, input int kt);
    hold({tag, ".rst"}, S_RST, RP);
    hold({tag, ".pll"}, S_PLL, kp);
    check_state({tag, ".pll"}, S_PLL);
    qpll_lock = 1;
    step();
    hold({tag, ".tx"}, S_TX, kt);
    check_state({tag, ".tx"}, S_TX);
    tx_reset_done = 1; userclk_tx_active = 1;
    step();
  endtask

  // From the first WAIT_RX sample to the first LINK_UP sample.
  task automatic rx_to_link(input string tag, input int kr, input int g);
    hold({tag, ".rx"}, S_RX, kr);
    check_state({tag, ".rx"}, S_RX);
    rx_reset_done = 1; userclk_rx_active = 1;
    step();
    hold({tag, ".blk"}, S_BLK, g);
    check_state({tag, ".blk"}, S_BLK);
    rx_block_lock = 1; rx_high_ber = 0;
    step();
    hold({tag, ".blk"}, S_BLK, LS - 1);
    m_retry = 0;
    check_state({tag, ".up"}, S_UP);
  endtask

  // From a LINK_UP sample: a one-cycle PHY loss, then recovery back to LINK_UP.
  task automatic drop_cycle(input string tag, input int use_ber, input logic clr);
    check_state({tag, ".up"}, S_UP);
    if (use_ber != 0) rx_high_ber = 1;
    else              rx_block_lock = 0;
    clr_counters = clr;
    step();
    clr_counters = 0; rx_high_ber = 0; rx_block_lock = 1;
    if (clr)                   m_drops = 0;
    else if (m_drops < 65535)  m_drops = m_drops + 1;
    hold({tag, ".rxr"}, S_RXR, RRP);
    hold({tag, ".rx"}, S_RX, 1);
    hold({tag, ".blk"}, S_BLK, LS);
    check_state({tag, ".up"}, S_UP);
  endtask

  initial begin
    int kp, kt, kr, g;

    // Reset state
    repeat (2) step();
    check_state("reset", S_DIS);
    rst_n = 1;
    step();
    check_state("idle", S_DIS);

    // Clean bring-up: each status 2 cycles into its stage, block lock already good
    enable = 1; pll_lock = 1;
    step();
    to_wait_rx("t1", 2, 2);
    hold("t1.rx", S_RX, 2);
    check_state("t1.rx", S_RX);
    rx_reset_done = 1; userclk_rx_active = 1; rx_block_lock = 1;
    step();
    hold("t1.blk", S_BLK, LS);
    check_state("t1.up", S_UP);

    // Single-cycle block-lock loss
    hold("t3.up", S_UP, 3);
    drop_cycle("t3", 0, 1'b0);

    // High BER toggling every 5 cycles in WAIT_BLOCK never reaches 8 good cycles
    rx_high_ber = 1;
    step();
    m_drops = m_drops + 1;
    hold("t4.rxr", S_RXR, RRP);
    hold("t4.rx", S_RX, 1);
    for (int j = 0; j < LT; j++) begin
      check_state("t4.blk", S_BLK);
      rx_high_ber = ((j / 5) % 2 == 0);
      step();
    end
    m_retry = 1;
    check_state("t4.timeout", S_RXR);
    rx_high_ber = 0;
    hold("t4.rxr", S_RXR, RRP);
    hold("t4.rx", S_RX, 1);
    hold("t4.blk", S_BLK, LS);
    m_retry = 0;
    check_state("t4.up", S_UP);

    // Losing QPLL lock in LINK_UP forces a full reset without a retry or drop
    status_low();
    step();
    check_state("qloss.rst", S_RST);
    to_wait_rx("qloss", $urandom_range(0, ST - 1), $urandom_range(0, ST - 1));
    rx_to_link("qloss", $urandom_range(0, ST - 1), $urandom_range(0, LT - LS));

    // Randomized re-bring-ups; the first uses the exit-versus-timeout boundary
    for (int it = 0; it < 5; it++) begin
      if ($urandom_range(0, 1) == 0) enable = 0;
      else                           pll_lock = 0;
      step();
      m_retry = 0;
      check_state("rnd.dis", S_DIS);
      status_low();
      enable = 1; pll_lock = 1;
      step();
      kp = (it == 0) ? ST - 1 : $urandom_range(0, ST - 1);
      kt = (it == 0) ? ST - 1 : $urandom_range(0, ST - 1);
      kr = (it == 0) ? ST - 1 : $urandom_range(0, ST - 1);
      g  = (it == 0) ? LT - LS : $urandom_range(0, LT - LS);
      to_wait_rx("rnd", kp, kt);
      rx_to_link("rnd", kr, g);
      for (int d = 0; d < int'($urandom_range(1, 3)); d++) begin
        hold("rnd.up", S_UP, $urandom_range(0, 4));
        drop_cycle("rnd", $urandom_range(0, 1), 1'b0);
      end
    end

    // pll_lock dropped in WAIT_RX; then an async reset during LINK_UP
    status_low();
    pll_lock = 0;
    step();
    check_state("t5.dis", S_DIS);
    pll_lock = 1;
    step();
    to_wait_rx("t5", 1, 1);
    hold("t5.rx", S_RX, 2);
    check_state("t5.rx", S_RX);
    pll_lock = 0;
    step();
    check_state("t5.pll_drop", S_DIS);
    status_low();
    pll_lock = 1;
    step();
    to_wait_rx("t5b", 2, 2);
    rx_to_link("t5b", 2, 2);
    hold("t5b.up", S_UP, 2);
    rst_n = 0;
    #1;
    m_retry = 0; m_drops = 0;
    check_state("t5.async_rst", S_DIS);
    step();
    rst_n = 1;
    status_low();
    enable = 0;
    step();
    check_state("t5.after_rst", S_DIS);

    // QPLL never locks: three stage timeouts end in FAULT
    enable = 1;
    step();
    for (int r = 1; r <= MR; r++) begin
      hold("t2.rst", S_RST, RP);
      hold("t2.pll", S_PLL, ST);
      m_retry = r;
    end
    hold("t2.fault", S_FLT, 5);
    check_state("t2.fault", S_FLT);
    enable = 0;
    step();
    m_retry = 0;
    check_state("t2.dis", S_DIS);

    // link_drops saturation, and a clear that coincides with a drop
    enable = 1;
    step();
    to_wait_rx("t6", 0, 0);
    rx_to_link("t6", 0, 0);
    force dut.drops_q = 16'hFFFD;
    step();
    release dut.drops_q;
    m_drops = 65533;
    check_state("t6.preset", S_UP);
    for (int d = 0; d < 4; d++) drop_cycle("t6.sat", $urandom_range(0, 1), 1'b0);
    drop_cycle("t6.clr_drop", 0, 1'b1);
    drop_cycle("t6.one", 1, 1'b0);
    clr_counters = 1;
    step();
    clr_counters = 0;
    m_drops = 0;
    check_state("t6.clr", S_UP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
